// File: rtl/mem_access_unit.sv
// mem_access_unit: MIPS M-stage data-memory unit.
// Decodes loads/stores, writes byte lanes into an internal RAM, returns
// extended load data after READ_LAT cycles while stalling the pipeline,
// and raises registered address-error pulses for misaligned accesses.
module mem_access_unit #(
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc_add_4,
    input  logic [31:0] mem_addr,
    input  logic [31:0] wdata_e,
    input  logic [31:0] wdata_w,
    input  logic        sel_fwd,
    output logic [31:0] alu_result,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        wr_log_en,
    output logic [31:0] wr_log_pc,
    output logic [31:0] wr_log_addr,
    output logic [31:0] wr_log_data
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(READ_LAT - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_nextState;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_ldIdx;
    logic [1:0]    r_ldSize;
    logic          r_ldSigned;
    logic [1:0]    r_ldLane;
    logic [31:0]   r_rdata;
    logic          r_excAdel;
    logic          r_excAdes;
    logic          r_logEn;
    logic [31:0]   r_logPc;
    logic [31:0]   r_logAddr;
    logic [31:0]   r_logData;
    logic [31:0]   r_ram [DEPTH];

    logic          w_isLoad;
    logic          w_isStore;
    logic [1:0]    w_size;
    logic          w_signed;
    logic          w_aligned;
    logic          w_idle;
    logic          w_loadAccept;
    logic          w_storeCommit;
    logic          w_adel;
    logic          w_ades;
    logic [31:0]   w_storeData;
    logic [AW-1:0] w_wrIdx;
    logic [3:0]    w_be;
    logic [31:0]   w_wrWord;
    logic [31:0]   w_mergedWord;
    logic [AW-1:0] w_rdIdx;
    logic [1:0]    w_rdSize;
    logic          w_rdSigned;
    logic [1:0]    w_rdLane;
    logic [4:0]    w_shamt;
    logic [31:0]   w_shifted;
    logic [31:0]   w_extended;
    logic          w_unused;

    assign w_unused   = &{1'b0, instr[25:21], instr[15:0]};
    assign alu_result = mem_addr;

    // Opcode decode into access class, size and signedness; unknown opcodes do nothing.
    always_comb begin
        w_isLoad  = 1'b0;
        w_isStore = 1'b0;
        w_size    = SZ_WORD;
        w_signed  = 1'b0;
        case (instr[31:26])
            OP_LW:  begin w_isLoad  = 1'b1; w_size = SZ_WORD; end
            OP_LB:  begin w_isLoad  = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
            OP_LBU: begin w_isLoad  = 1'b1; w_size = SZ_BYTE; end
            OP_LH:  begin w_isLoad  = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
            OP_LHU: begin w_isLoad  = 1'b1; w_size = SZ_HALF; end
            OP_SW:  begin w_isStore = 1'b1; w_size = SZ_WORD; end
            OP_SB:  begin w_isStore = 1'b1; w_size = SZ_BYTE; end
            OP_SH:  begin w_isStore = 1'b1; w_size = SZ_HALF; end
            default: ;
        endcase
    end

    assign w_aligned = (w_size == SZ_WORD) ? (mem_addr[1:0] == 2'b00) :
                       (w_size == SZ_HALF) ? (mem_addr[0] == 1'b0) : 1'b1;

    // Requests are only looked at in IDLE; WAIT and DONE belong to the outstanding load.
    assign w_idle        = (r_state == S_IDLE);
    assign w_loadAccept  = w_idle & req_valid & w_isLoad  &  w_aligned;
    assign w_storeCommit = w_idle & req_valid & w_isStore &  w_aligned;
    assign w_adel        = w_idle & req_valid & w_isLoad  & ~w_aligned;
    assign w_ades        = w_idle & req_valid & w_isStore & ~w_aligned;

    assign w_storeData = (instr[20:16] == 5'd0) ? 32'd0 : (sel_fwd ? wdata_w : wdata_e);
    assign w_wrIdx     = mem_addr[AW+1:2];

    // Byte-lane enables and lane-replicated write data for the store size.
    always_comb begin
        w_be     = 4'b1111;
        w_wrWord = w_storeData;
        case (w_size)
            SZ_BYTE: begin
                w_be     = 4'b0001 << mem_addr[1:0];
                w_wrWord = {4{w_storeData[7:0]}};
            end
            SZ_HALF: begin
                w_be     = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wrWord = {2{w_storeData[15:0]}};
            end
            default: ;
        endcase
    end

    // Word as it will look after the store, reported through the write log.
    always_comb begin
        w_mergedWord = r_ram[w_wrIdx];
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) w_mergedWord[8*i +: 8] = w_wrWord[8*i +: 8];
        end
    end

    // Byte-enabled RAM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_storeCommit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_ram[w_wrIdx][8*i +: 8] <= w_wrWord[8*i +: 8];
            end
        end
    end

    // Read side uses the live request in IDLE (READ_LAT==1 case) and the captured one afterwards.
    assign w_rdIdx    = w_idle ? w_wrIdx        : r_ldIdx;
    assign w_rdSize   = w_idle ? w_size         : r_ldSize;
    assign w_rdSigned = w_idle ? w_signed       : r_ldSigned;
    assign w_rdLane   = w_idle ? mem_addr[1:0]  : r_ldLane;

    // Shift the addressed byte/half down to bit 0, then sign- or zero-extend it.
    always_comb begin
        w_shamt = 5'd0;
        if (w_rdSize == SZ_BYTE)      w_shamt = {w_rdLane, 3'b000};
        else if (w_rdSize == SZ_HALF) w_shamt = {w_rdLane[1], 4'b0000};
        w_shifted  = r_ram[w_rdIdx] >> w_shamt;
        w_extended = w_shifted;
        if (w_rdSize == SZ_BYTE)
            w_extended = {{24{w_rdSigned & w_shifted[7]}}, w_shifted[7:0]};
        else if (w_rdSize == SZ_HALF)
            w_extended = {{16{w_rdSigned & w_shifted[15]}}, w_shifted[15:0]};
    end

    // Load FSM next-state: single-cycle loads skip WAIT entirely.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (w_loadAccept) w_nextState = (READ_LAT == 1) ? S_DONE : S_WAIT;
            S_WAIT:  if (r_cnt == 4'd1) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Load FSM state, latency counter, captured request and returned data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_ldIdx    <= '0;
            r_ldSize   <= SZ_WORD;
            r_ldSigned <= 1'b0;
            r_ldLane   <= 2'b00;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_nextState;
            if (w_loadAccept) begin
                r_cnt      <= CNT_INIT;
                r_ldIdx    <= w_wrIdx;
                r_ldSize   <= w_size;
                r_ldSigned <= w_signed;
                r_ldLane   <= mem_addr[1:0];
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_nextState == S_DONE) r_rdata <= w_extended;
        end
    end

    // Exception pulses and the store write log, all valid for the cycle after the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_excAdel <= 1'b0;
            r_excAdes <= 1'b0;
            r_logEn   <= 1'b0;
            r_logPc   <= 32'd0;
            r_logAddr <= 32'd0;
            r_logData <= 32'd0;
        end else begin
            r_excAdel <= w_adel;
            r_excAdes <= w_ades;
            r_logEn   <= w_storeCommit;
            if (w_storeCommit) begin
                r_logPc   <= pc_add_4 - 32'd4;
                r_logAddr <= {mem_addr[31:2], 2'b00};
                r_logData <= w_mergedWord;
            end
        end
    end

    assign stall       = w_loadAccept | (r_state == S_WAIT);
    assign rdata_valid = (r_state == S_DONE);
    assign rdata       = r_rdata;
    assign exc_adel    = r_excAdel;
    assign exc_ades    = r_excAdes;
    assign wr_log_en   = r_logEn;
    assign wr_log_pc   = r_logPc;
    assign wr_log_addr = r_logAddr;
    assign wr_log_data = r_logData;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a byte-addressed
// reference memory; expected events are queued at issue time and a negedge
// monitor pops them as the DUT raises rdata_valid / exc_* / wr_log_en.
module tb_mem_access_unit;

    localparam int DEPTH    = 64;
    localparam int READ_LAT = 3;
    localparam int NBYTES   = 4 * DEPTH;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_NOP = 6'b001000;

    localparam int EV_RDATA = 0;
    localparam int EV_ADEL  = 1;
    localparam int EV_ADES  = 2;
    localparam int EV_WLOG  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic [31:0] pc_add_4 = 32'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] wdata_e = 32'd0;
    logic [31:0] wdata_w = 32'd0;
    logic        sel_fwd = 1'b0;
    logic [31:0] alu_result;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        wr_log_en;
    logic [31:0] wr_log_pc;
    logic [31:0] wr_log_addr;
    logic [31:0] wr_log_data;

    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    exp_t        sbq[$];
    logic [7:0]  mdl [NBYTES];
    logic [31:0] lastRdata = 32'd0;

    mem_access_unit #(.DEPTH(DEPTH), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .instr(instr),
        .pc_add_4(pc_add_4), .mem_addr(mem_addr), .wdata_e(wdata_e),
        .wdata_w(wdata_w), .sel_fwd(sel_fwd), .alu_result(alu_result),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .wr_log_en(wr_log_en),
        .wr_log_pc(wr_log_pc), .wr_log_addr(wr_log_addr), .wr_log_data(wr_log_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit isLoadOp(input logic [5:0] op);
        return op == OP_LW || op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU;
    endfunction

    function automatic bit isStoreOp(input logic [5:0] op);
        return op == OP_SW || op == OP_SB || op == OP_SH;
    endfunction

    function automatic int bytesOf(input logic [5:0] op);
        if (op == OP_LW || op == OP_SW) return 4;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
        return 1;
    endfunction

    function automatic int wrapAddr(input logic [31:0] addr);
        return int'(addr % NBYTES);
    endfunction

    function automatic logic [31:0] modelWord(input int a);
        int w = a - (a % 4);
        return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
    endfunction

    function automatic logic [31:0] modelLoad(input logic [5:0] op, input logic [31:0] addr);
        int a = wrapAddr(addr);
        logic [15:0] h = {mdl[(a+1) % NBYTES], mdl[a]};
        case (op)
            OP_LB:   return 32'($signed(mdl[a]));
            OP_LBU:  return {24'd0, mdl[a]};
            OP_LH:   return 32'($signed(h));
            OP_LHU:  return {16'd0, h};
            default: return modelWord(a);
        endcase
    endfunction

    task automatic modelStore(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] d);
        int a = wrapAddr(addr);
        for (int i = 0; i < bytesOf(op); i++) mdl[a+i] = d[8*i +: 8];
    endtask

    // Pop the oldest expectation for a DUT event and compare kind, timing and payload.
    task automatic popCheck(input int kind, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput("event_expected", 32'(kind + 100), 32'd0);
            return;
        end
        e = sbq.pop_front();
        checkOutput("event_kind", 32'(kind), 32'(e.kind));
        checkOutput("event_cycle", 32'(cyc), 32'(e.cyc));
        if (kind == EV_RDATA && e.kind == EV_RDATA) checkOutput("rdata", a0, e.d0);
        if (kind == EV_WLOG && e.kind == EV_WLOG) begin
            checkOutput("wr_log_pc", a0, e.d0);
            checkOutput("wr_log_addr", a1, e.d1);
            checkOutput("wr_log_data", a2, e.d2);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (rdata_valid) popCheck(EV_RDATA, rdata, 32'd0, 32'd0);
            if (exc_adel)    popCheck(EV_ADEL, 32'd0, 32'd0, 32'd0);
            if (exc_ades)    popCheck(EV_ADES, 32'd0, 32'd0, 32'd0);
            if (wr_log_en)   popCheck(EV_WLOG, wr_log_pc, wr_log_addr, wr_log_data);
        end
    end

    // Issue one M-stage instruction (called at posedge+1), queue its expected outcome,
    // check stall each cycle it occupies, and return at posedge+1 of the next free cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] addr,
                                 input logic [31:0] we, input logic [31:0] ww, input logic sel);
        exp_t        e;
        logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
        logic [31:0] sd = (rt == 5'd0) ? 32'd0 : (sel ? ww : we);
        bit          aligned = (addr % bytesOf(op)) == 0;
        int          occupy = 1;
        req_valid = 1'b1;
        instr     = {op, 5'($urandom), rt, 16'($urandom)};
        pc_add_4  = pc + 32'd4;
        mem_addr  = addr;
        wdata_e   = we;
        wdata_w   = ww;
        sel_fwd   = sel;
        e.cyc = cyc + 1;
        e.d0 = 32'd0; e.d1 = 32'd0; e.d2 = 32'd0;
        if (isLoadOp(op) && aligned) begin
            e.kind = EV_RDATA; e.cyc = cyc + READ_LAT; e.d0 = modelLoad(op, addr);
            lastRdata = e.d0;
            sbq.push_back(e);
            occupy = READ_LAT + 1;
        end else if (isLoadOp(op)) begin
            e.kind = EV_ADEL; sbq.push_back(e);
        end else if (isStoreOp(op) && aligned) begin
            modelStore(op, addr, sd);
            e.kind = EV_WLOG; e.d0 = pc; e.d1 = addr & 32'hFFFF_FFFC;
            e.d2 = modelWord(wrapAddr(addr));
            sbq.push_back(e);
        end else if (isStoreOp(op)) begin
            e.kind = EV_ADES; sbq.push_back(e);
        end
        for (int k = 0; k < occupy; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("alu_result", alu_result, addr);
            checkOutput("stall", 32'(stall), 32'(k < occupy - 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic idleCycles(input int n);
        req_valid = 1'b0;
        instr     = 32'd0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_exc", 32'({exc_adel, exc_ades}), 32'd0);
        checkOutput("reset_wr_log_en", 32'(wr_log_en), 32'd0);
        checkOutput("reset_wr_log_data", wr_log_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Give every RAM word a known value
        for (int w = 0; w < DEPTH; w++)
            applyStimulus(OP_SW, 5'd1, 32'(4 * w), $urandom, $urandom, 1'($urandom));

        // Word store then sub-word loads, including load right after the store
        applyStimulus(OP_SW,  5'd5, 32'h10, 32'h1122_3344, 32'h0, 1'b0);
        applyStimulus(OP_LB,  5'd6, 32'h13, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_LH,  5'd6, 32'h12, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_LBU, 5'd6, 32'h10, 32'h0, 32'h0, 1'b0);

        // Byte store with sign bit set, then signed/unsigned/word readback
        applyStimulus(OP_SW,  5'd5, 32'h20, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_SB,  5'd5, 32'h21, 32'hABCD_EF80, 32'h0, 1'b0);
        applyStimulus(OP_LB,  5'd6, 32'h21, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_LBU, 5'd6, 32'h21, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_LW,  5'd6, 32'h20, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_SH,  5'd5, 32'h22, 32'h0000_9ABC, 32'h0, 1'b0);
        applyStimulus(OP_LHU, 5'd6, 32'h22, 32'h0, 32'h0, 1'b0);

        // Misaligned accesses
        applyStimulus(OP_LW,  5'd6, 32'h02, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_SH,  5'd5, 32'h05, 32'h5555_5555, 32'h0, 1'b0);
        applyStimulus(OP_LW,  5'd6, 32'h04, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_LHU, 5'd6, 32'h13, 32'h0, 32'h0, 1'b0);

        // rt==0 forces zero; sel_fwd picks the W-stage value
        applyStimulus(OP_SW,  5'd0, 32'h30, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        applyStimulus(OP_LW,  5'd6, 32'h30, 32'h0, 32'h0, 1'b0);
        applyStimulus(OP_SW,  5'd7, 32'h34, 32'h1111_1111, 32'hCAFE_F00D, 1'b1);
        applyStimulus(OP_LW,  5'd6, 32'h34, 32'h0, 32'h0, 1'b0);

        // Address wrap beyond the RAM size
        applyStimulus(OP_SW,  5'd7, 32'(NBYTES + 'h18), 32'h0BAD_F00D, 32'h0, 1'b0);
        applyStimulus(OP_LW,  5'd6, 32'h18, 32'h0, 32'h0, 1'b0);

        // rdata holds its value through an unrelated instruction
        applyStimulus(OP_NOP, 5'd3, 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("rdata_hold", rdata, lastRdata);
        @(posedge clk); #1;

        // Reset in the middle of an outstanding load drops it
        req_valid = 1'b1;
        instr     = {OP_LW, 5'd0, 5'd6, 16'd0};
        mem_addr  = 32'h10;
        @(negedge clk);
        checkOutput("midload_stall_before", 32'(stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        req_valid = 1'b0;
        #1;
        checkOutput("midload_stall_after_reset", 32'(stall), 32'd0);
        checkOutput("midload_rdata_valid", 32'(rdata_valid), 32'd0);
        checkOutput("midload_rdata", rdata, 32'd0);
        checkOutput("midload_wr_log_addr", wr_log_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idleCycles(READ_LAT + 2);
        applyStimulus(OP_LW, 5'd6, 32'h10, 32'h0, 32'h0, 1'b0);

        // Randomised mix of all opcodes
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  ops [9] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, OP_NOP};
            logic [31:0] a = $urandom;
            logic [4:0]  rt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if ($urandom_range(0, 9) < 6) a = a & 32'hFFFF_FFFC;
            applyStimulus(ops[$urandom_range(0, 8)], rt, a, $urandom, $urandom, 1'($urandom));
            if ($urandom_range(0, 7) == 0) idleCycles(1);
        end

        idleCycles(READ_LAT + 3);
        checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
